id_stage: RTL and testbench

Instruction-decode stage of the pipelined MIPS-subset core. Sits between instruction fetch and the execute stage and produces the registered operand and control bundle the execute stage consumes: rs, rt, sign_ext, ALUSrc, ALUOp, funct, branch, pc. Contains the 32x32 register file with write-back bypass, the main control decoder and load-use hazard detection. Issues one bubble on a load-use dependency and drops the decoded instruction on a flush.

---
 rtl/id_stage.sv | 189 ++++++++++++++++++
 tb/tb_id_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode: register file with write-back bypass, control decode,
// load-use hazard detection, and the registered ID/EX bundle for execute.
// Latency 1 cycle. A load-use hit stalls fetch and inserts one bubble; flush drops the instruction.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic        if_valid,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        stall_if,
  output logic        illegal,
  output logic        valid,
  output logic [31:0] rs,
  output logic [31:0] rt,
  output logic [31:0] sign_ext,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic [5:0]  funct,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [4:0]  dest_reg,
  output logic [31:0] pc
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [31:0] r_rf [32];

  logic        r_illegal, r_valid, r_alusrc, r_branch, r_mem_read;
  logic        r_mem_write, r_reg_write, r_mem_to_reg;
  logic [31:0] r_rs, r_rt, r_sext, r_pc;
  logic [1:0]  r_aluop;
  logic [5:0]  r_funct;
  logic [4:0]  r_dest;

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs_idx, w_rt_idx, w_rd_idx;
  logic [31:0] w_rs_val, w_rt_val, w_sext;
  logic        w_legal, w_uses_rt, w_hazard, w_issue;
  logic        w_alusrc, w_branch, w_mem_read, w_mem_write, w_reg_write, w_mem_to_reg;
  logic [1:0]  w_aluop;
  logic [4:0]  w_dest;

  assign w_opcode = instr[31:26];
  assign w_rs_idx = instr[25:21];
  assign w_rt_idx = instr[20:16];
  assign w_rd_idx = instr[15:11];
  assign w_sext   = {{16{instr[15]}}, instr[15:0]};

  // Register reads: r0 is hard zero; a same-cycle write-back is forwarded.
  always_comb begin
    w_rs_val = r_rf[w_rs_idx];
    w_rt_val = r_rf[w_rt_idx];
    if (wb_en && (wb_reg == w_rs_idx)) w_rs_val = wb_data;
    if (wb_en && (wb_reg == w_rt_idx)) w_rt_val = wb_data;
    if (w_rs_idx == 5'd0) w_rs_val = '0;
    if (w_rt_idx == 5'd0) w_rt_val = '0;
  end

  // Main control decode; unknown opcodes leave w_legal low.
  always_comb begin
    w_legal      = 1'b1;
    w_uses_rt    = 1'b0;
    w_alusrc     = 1'b0;
    w_aluop      = 2'b00;
    w_branch     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_dest       = 5'd0;
    case (w_opcode)
      OP_RTYPE: begin
        w_uses_rt   = 1'b1;
        w_aluop     = 2'b10;
        w_reg_write = 1'b1;
        w_dest      = w_rd_idx;
      end
      OP_LW: begin
        w_alusrc     = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_dest       = w_rt_idx;
      end
      OP_SW: begin
        w_uses_rt   = 1'b1;
        w_alusrc    = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_ADDI: begin
        w_alusrc    = 1'b1;
        w_reg_write = 1'b1;
        w_dest      = w_rt_idx;
      end
      OP_BEQ: begin
        w_uses_rt = 1'b1;
        w_aluop   = 2'b01;
        w_branch  = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Load-use: the load in ID/EX has no data yet, so a dependent instruction waits one cycle.
  // Flush overrides so fetch is free to redirect.
  assign w_hazard = if_valid && !flush && r_valid && r_mem_read && (r_dest != 5'd0) &&
                    ((r_dest == w_rs_idx) || (w_uses_rt && (r_dest == w_rt_idx)));
  assign w_issue  = if_valid && !flush && !w_hazard;
  assign stall_if = w_hazard;

  // Register file write port; r0 is never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (wb_en && (wb_reg != 5'd0)) begin
      r_rf[wb_reg] <= wb_data;
    end
  end

  // ID/EX register: real instruction on issue, otherwise an all-zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || !(w_issue && w_legal)) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_sext       <= '0;
      r_alusrc     <= 1'b0;
      r_aluop      <= 2'b00;
      r_funct      <= '0;
      r_branch     <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_dest       <= '0;
      r_pc         <= '0;
    end else begin
      r_valid      <= 1'b1;
      r_rs         <= w_rs_val;
      r_rt         <= w_rt_val;
      r_sext       <= w_sext;
      r_alusrc     <= w_alusrc;
      r_aluop      <= w_aluop;
      r_funct      <= instr[5:0];
      r_branch     <= w_branch;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_reg_write  <= w_reg_write;
      r_mem_to_reg <= w_mem_to_reg;
      r_dest       <= w_dest;
      r_pc         <= pc_in;
    end
  end

  // Illegal-opcode pulse, raised only when the instruction would otherwise have issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_illegal <= 1'b0;
    else       r_illegal <= w_issue && !w_legal;
  end

  assign illegal    = r_illegal;
  assign valid      = r_valid;
  assign rs         = r_rs;
  assign rt         = r_rt;
  assign sign_ext   = r_sext;
  assign ALUSrc     = r_alusrc;
  assign ALUOp      = r_aluop;
  assign funct      = r_funct;
  assign branch     = r_branch;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign reg_write  = r_reg_write;
  assign mem_to_reg = r_mem_to_reg;
  assign dest_reg   = r_dest;
  assign pc         = r_pc;

endmodule

// File: tb/tb_id_stage.sv
// Directed plus randomized bench for id_stage against a behavioural decode model.
module tb_id_stage;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_ADDI= 6'b001000;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] sext;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        branch;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        m2r;
    logic [4:0]  dest;
    logic [31:0] pc;
  } bnd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, pc_in, wb_data;
  logic        if_valid, flush, wb_en;
  logic [4:0]  wb_reg;
  logic        stall_if, illegal, valid, ALUSrc, branch, mem_read, mem_write, reg_write, mem_to_reg;
  logic [31:0] rs, rt, sign_ext, pc;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [4:0]  dest_reg;

  id_stage dut (
    .clk(clk), .reset(reset), .instr(instr), .pc_in(pc_in), .if_valid(if_valid),
    .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .stall_if(stall_if), .illegal(illegal), .valid(valid), .rs(rs), .rt(rt),
    .sign_ext(sign_ext), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .funct(funct),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .dest_reg(dest_reg), .pc(pc)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mrf [32];
  bnd_t        mprev;
  logic        last_stall;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bnd_t e);
    chk("valid", valid, e.valid);
    chk("illegal", illegal, e.illegal);
    chk("rs", rs, e.rs);
    chk("rt", rt, e.rt);
    chk("sign_ext", sign_ext, e.sext);
    chk("ALUSrc", ALUSrc, e.alusrc);
    chk("ALUOp", ALUOp, e.aluop);
    chk("funct", funct, e.funct);
    chk("branch", branch, e.branch);
    chk("mem_read", mem_read, e.mr);
    chk("mem_write", mem_write, e.mw);
    chk("reg_write", reg_write, e.rw);
    chk("mem_to_reg", mem_to_reg, e.m2r);
    chk("dest_reg", dest_reg, e.dest);
    chk("pc", pc, e.pc);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    mprev = '0;
  endfunction

  // Architectural read as seen by decode: r0 is zero, a same-cycle write-back wins.
  function automatic logic [31:0] rd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_en && wb_reg == idx) return wb_data;
    return mrf[idx];
  endfunction

  function automatic bnd_t model_issue(input logic [31:0] ins, input logic [31:0] p);
    bnd_t o = '0;
    o.valid = 1'b1;
    o.rs    = rd(ins[25:21]);
    o.rt    = rd(ins[20:16]);
    o.sext  = {{16{ins[15]}}, ins[15:0]};
    o.funct = ins[5:0];
    o.pc    = p;
    if (ins[31:26] == OP_R) begin
      o.aluop = 2'b10; o.rw = 1'b1; o.dest = ins[15:11];
    end else if (ins[31:26] == OP_LW) begin
      o.alusrc = 1'b1; o.mr = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.dest = ins[20:16];
    end else if (ins[31:26] == OP_SW) begin
      o.alusrc = 1'b1; o.mw = 1'b1;
    end else if (ins[31:26] == OP_ADDI) begin
      o.alusrc = 1'b1; o.rw = 1'b1; o.dest = ins[20:16];
    end else begin
      o.aluop = 2'b01; o.branch = 1'b1;
    end
    return o;
  endfunction

  task automatic step(input logic [31:0] ins, input logic [31:0] p, input logic ifv, input logic fl,
                      input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd);
    logic [5:0] opc;
    logic       legal, urt, haz;
    bnd_t       nxt;
    instr = ins; pc_in = p; if_valid = ifv; flush = fl;
    wb_en = wbe; wb_reg = wbr; wb_data = wbd;
    @(negedge clk);
    opc   = ins[31:26];
    legal = (opc == OP_R) || (opc == OP_LW) || (opc == OP_SW) || (opc == OP_ADDI) || (opc == OP_BEQ);
    urt   = (opc == OP_R) || (opc == OP_SW) || (opc == OP_BEQ);
    haz   = ifv && !fl && mprev.valid && mprev.mr && (mprev.dest != 5'd0) &&
            ((mprev.dest == ins[25:21]) || (urt && mprev.dest == ins[20:16]));
    last_stall = stall_if;
    chk("stall_if", stall_if, haz);
    nxt = '0;
    if (ifv && !fl && !haz) begin
      if (legal) nxt = model_issue(ins, p);
      else       nxt.illegal = 1'b1;
    end
    @(posedge clk);
    if (wbe && wbr != 5'd0) mrf[wbr] = wbd;
    mprev = nxt;
    #1;
    check_all(mprev);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] v;
    int          k;
    logic [5:0]  bad [4];
    bad[0] = 6'b000001; bad[1] = 6'b111111; bad[2] = 6'b010000; bad[3] = 6'b000010;
    v = $urandom;
    v[25:21] = 5'($urandom_range(0, 7));
    v[20:16] = 5'($urandom_range(0, 7));
    v[15:11] = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: begin v[31:26] = OP_R; v[5:0] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 2)); end
      3, 4, 8: v[31:26] = OP_LW;
      5:       v[31:26] = OP_SW;
      6:       v[31:26] = OP_ADDI;
      7:       v[31:26] = OP_BEQ;
      default: v[31:26] = bad[$urandom_range(0, 3)];
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] cur, cur_pc;
    logic        hold;
    reset = 1'b1; instr = '0; pc_in = '0; if_valid = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0; last_stall = 1'b0;
    model_reset();
    #3;
    check_all(mprev);
    chk("reset_stall_if", stall_if, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Bypass: write r3 while decoding ADD r1,r3,r3.
    step(32'h00630820, 32'h100, 1, 0, 1, 5'd3, 32'h1234);
    chk("bypass_rs", rs, 32'h1234);
    chk("bypass_rt", rt, 32'h1234);
    chk("add_aluop", ALUOp, 2'b10);
    chk("add_dest", dest_reg, 5'd1);
    chk("add_regwrite", reg_write, 1'b1);

    // ADDI r2,r0,-4.
    step(32'h2002FFFC, 32'h104, 1, 0, 0, 5'd0, 32'h0);
    chk("addi_sext", sign_ext, 32'hFFFFFFFC);
    chk("addi_alusrc", ALUSrc, 1'b1);
    chk("addi_dest", dest_reg, 5'd2);
    chk("addi_rs", rs, 32'h0);

    // LW r4,0(r1) then ADD r5,r4,r4: one stall, one bubble, then issue.
    step(32'h8C240000, 32'h108, 1, 0, 0, 5'd0, 32'h0);
    chk("lw_memread", mem_read, 1'b1);
    step(32'h00842820, 32'h10C, 1, 0, 0, 5'd0, 32'h0);
    chk("loaduse_stall", last_stall, 1'b1);
    chk("loaduse_bubble", valid, 1'b0);
    step(32'h00842820, 32'h10C, 1, 0, 0, 5'd0, 32'h0);
    chk("loaduse_nostall", last_stall, 1'b0);
    chk("loaduse_issue", valid, 1'b1);
    chk("loaduse_pc", pc, 32'h10C);

    // BEQ under flush with a write to r0, then ADD r6,r0,r0.
    step(32'h10220003, 32'h110, 1, 1, 1, 5'd0, 32'hDEADBEEF);
    chk("flush_bubble", valid, 1'b0);
    chk("flush_stall", last_stall, 1'b0);
    step(32'h00003020, 32'h200, 1, 0, 0, 5'd0, 32'h0);
    chk("r0_zero", rs, 32'h0);
    chk("after_flush_valid", valid, 1'b1);

    // Unknown opcode, then SW r2,8(r1).
    step(32'hFC000000, 32'h204, 1, 0, 0, 5'd0, 32'h0);
    chk("illegal_pulse", illegal, 1'b1);
    chk("illegal_bubble", valid, 1'b0);
    step(32'hAC220008, 32'h208, 1, 0, 0, 5'd0, 32'h0);
    chk("illegal_clear", illegal, 1'b0);
    chk("sw_memwrite", mem_write, 1'b1);
    chk("sw_alusrc", ALUSrc, 1'b1);

    // Randomized traffic; fetch holds the instruction while stall_if is high.
    cur = '0; cur_pc = 32'h1000; hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic ifv;
      if (!hold) begin cur = rand_instr(); cur_pc = cur_pc + 32'd4; end
      ifv = hold ? 1'b1 : ($urandom_range(0, 9) != 0);
      step(cur, cur_pc, ifv, ($urandom_range(0, 11) == 0), 1'($urandom),
           5'($urandom_range(0, 7)), $urandom);
      hold = last_stall;
    end

    // Reset asserted while a load-use stall is pending.
    step(32'h8C240000, 32'h300, 1, 0, 0, 5'd0, 32'h0);
    instr = 32'h00842820; pc_in = 32'h304;
    @(negedge clk);
    #1;
    chk("midstall_stall", stall_if, 1'b1);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(mprev);
    chk("midstall_reset_stall", stall_if, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    // ADD r7,r5,r5 after reset: r5 reads zero, issues immediately.
    step(32'h00A53820, 32'h400, 1, 0, 0, 5'd0, 32'h0);
    chk("post_reset_r5", rs, 32'h0);
    chk("post_reset_valid", valid, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
